// File: rtl/add_pkg.sv
// Shared constants for the pipelined adder/subtractor: mode encoding and default geometry.
package add_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG = 8;
endpackage

// File: rtl/add_seg.sv
// Combinational W-bit ripple adder segment built from chained full-adder cells.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module add_seg
  import add_pkg::*;
#(
  parameter int W = DEFAULT_SEG
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic w_c;

  always_comb begin
    w_c   = cin;
    c_msb = 1'b0;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = w_c;
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit segment per stage, registered inter-stage
// carry, skew registers for pending operand and finished result segments, global-stall flow control.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int STAGES   = (WIDTH / SEG_SAFE < 1) ? 1 : WIDTH / SEG_SAFE;

  if ((SEG < 1) || (WIDTH % SEG_SAFE != 0)) begin : g_bad_param
    $error("add_pipe: WIDTH must be a positive multiple of SEG");
  end

  logic             w_stall;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic              r_ovf;
  logic              r_zero;

  logic [WIDTH-1:0]  w_seg_a;
  logic [WIDTH-1:0]  w_seg_b;
  logic [WIDTH-1:0]  w_seg_s;
  logic [STAGES-1:0] w_seg_ci;
  logic [STAGES-1:0] w_seg_co;
  logic [STAGES-1:0] w_seg_cm;
  logic [STAGES-1:0] w_ld;
  logic [WIDTH-1:0]  w_s_d [STAGES];

  assign w_stall  = r_vld[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_b_eff  = (sub == MODE_SUB) ? ~b : b;
  assign w_c_eff  = (sub == MODE_SUB) ? 1'b1 : cin;

  // Stage 0 works straight off the conditioned inputs; later stages off the skew registers.
  always_comb begin
    w_seg_a             = '0;
    w_seg_b             = '0;
    w_seg_ci            = '0;
    w_ld                = '0;
    w_seg_a[SEG_SAFE-1:0] = a[SEG_SAFE-1:0];
    w_seg_b[SEG_SAFE-1:0] = w_b_eff[SEG_SAFE-1:0];
    w_seg_ci[0]         = w_c_eff;
    w_ld[0]             = w_accept;
    for (int k = 1; k < STAGES; k++) begin
      w_seg_a[k*SEG_SAFE +: SEG_SAFE] = r_a[k-1][k*SEG_SAFE +: SEG_SAFE];
      w_seg_b[k*SEG_SAFE +: SEG_SAFE] = r_b[k-1][k*SEG_SAFE +: SEG_SAFE];
      w_seg_ci[k]                     = r_c[k-1];
      w_ld[k]                         = r_vld[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    add_seg #(
      .W(SEG_SAFE)
    ) u_seg (
      .a    (w_seg_a[k*SEG_SAFE +: SEG_SAFE]),
      .b    (w_seg_b[k*SEG_SAFE +: SEG_SAFE]),
      .cin  (w_seg_ci[k]),
      .sum  (w_seg_s[k*SEG_SAFE +: SEG_SAFE]),
      .cout (w_seg_co[k]),
      .c_msb(w_seg_cm[k])
    );
  end

  always_comb begin
    w_s_d[0]                = '0;
    w_s_d[0][SEG_SAFE-1:0]  = w_seg_s[SEG_SAFE-1:0];
    for (int k = 1; k < STAGES; k++) begin
      w_s_d[k]                          = r_s[k-1];
      w_s_d[k][k*SEG_SAFE +: SEG_SAFE]  = w_seg_s[k*SEG_SAFE +: SEG_SAFE];
    end
  end

  // Valid bits shift every unstalled cycle; data only loads behind a valid so bubbles leave it quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_ld[k];
        if (w_ld[k]) begin
          r_a[k] <= (k == 0) ? a : r_a[(k == 0) ? 0 : k-1];
          r_b[k] <= (k == 0) ? w_b_eff : r_b[(k == 0) ? 0 : k-1];
          r_s[k] <= w_s_d[k];
          r_c[k] <= w_seg_co[k];
        end
      end
      if (w_ld[STAGES-1]) begin
        r_ovf  <= w_seg_cm[STAGES-1] ^ w_seg_co[STAGES-1];
        r_zero <= ~|w_s_d[STAGES-1];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  logic w_unused;
  assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: three instances (32/8, 32/32, 16/4) driven one at a time,
// expected results queued at accept and compared in order as each instance drains.
module tb_add_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic        cin_d;
  logic        sub_d;
  logic        out_ready;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [2:0]  zr;
  logic [31:0] o0;
  logic [31:0] o1;
  logic [15:0] o2;

  int total = 0;
  int bad   = 0;
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic [34:0] q2[$];
  bit done;

  add_pipe #(.WIDTH(32), .SEG(8)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_d), .b(b_d),
    .cin(cin_d), .sub(sub_d), .out_valid(ov[0]), .out_ready(out_ready), .out(o0),
    .cout(co[0]), .overflow(of[0]), .zero(zr[0])
  );
  add_pipe #(.WIDTH(32), .SEG(32)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_d), .b(b_d),
    .cin(cin_d), .sub(sub_d), .out_valid(ov[1]), .out_ready(out_ready), .out(o1),
    .cout(co[1]), .overflow(of[1]), .zero(zr[1])
  );
  add_pipe #(.WIDTH(16), .SEG(4)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_d[15:0]),
    .b(b_d[15:0]), .cin(cin_d), .sub(sub_d), .out_valid(ov[2]), .out_ready(out_ready),
    .out(o2), .cout(co[2]), .overflow(of[2]), .zero(zr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wof(input int d);
    return (d == 2) ? 16 : 32;
  endfunction

  // Independent reference: wide integer add, overflow from operand/result signs.
  function automatic logic [34:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    longint unsigned m, aa, bb, s, r;
    logic c, v, z;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'h0, av} & m;
    bb = {32'h0, (sb ? ~bv : bv)} & m;
    s  = aa + bb + (sb ? 64'd1 : {63'd0, ci});
    r  = s & m;
    c  = s[w];
    v  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    z  = (r == 0);
    return {c, v, z, r[31:0]};
  endfunction

  function automatic logic [34:0] got_of(input int d);
    logic [31:0] o;
    o = (d == 0) ? o0 : (d == 1) ? o1 : {16'h0, o2};
    return {co[d], of[d], zr[d], o};
  endfunction

  task automatic push(input int d, input logic [34:0] e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int d);
    logic [34:0] e;
    int n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      check($sformatf("spurious_out%0d", d), {63'd0, ov[d]}, 64'd0);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("sb%0d", d), {29'd0, got_of(d)}, {29'd0, e});
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv,
                      input logic ci, input logic sb);
    bit acc;
    int n;
    a_d = av; b_d = bv; cin_d = ci; sub_d = sb;
    iv[d] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      #1;
      acc = ir[d];
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    iv[d] = 1'b0;
    check("accept", {63'd0, acc}, 64'd1);
    if (acc) push(d, model(wof(d), av, bv, ci, sb));
  endtask

  task automatic wait_res(input int d, input int lat, input logic [34:0] expv);
    int n;
    bit seen;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 20) begin
      #1;
      if (ov[d]) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check($sformatf("latency%0d", d), n, lat);
    check($sformatf("result%0d", d), {29'd0, got_of(d)}, {29'd0, expv});
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!reset && out_ready) begin
      for (int d = 0; d < 3; d++) if (ov[d]) mon(d);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; iv = '0; a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ov", {61'd0, ov}, 64'd0);
    check("rst_flags", {55'd0, co, of, zr}, 64'd0);
    check("rst_out", {o0, o1 | {16'h0, o2}}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_rst", {61'd0, ir}, 64'd7);
    @(negedge clk);

    send(0, 32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b0);
    wait_res(0, 4, {3'b000, 32'hFFFFFFFF});
    send(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_res(0, 4, {3'b101, 32'h00000000});
    send(0, 32'd5, 32'd7, 1'b0, 1'b1);
    wait_res(0, 4, {3'b000, 32'hFFFFFFFE});
    send(0, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    wait_res(0, 4, {3'b010, 32'h80000000});
    send(0, 32'd10, 32'd3, 1'b1, 1'b0);
    wait_res(0, 4, {3'b000, 32'd14});

    // Back-to-back with a four-cycle downstream stall.
    fork
      begin
        for (int i = 1; i <= 6; i++) send(0, i, i, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          #1;
          check("bp_ready", {63'd0, ir[0]}, 64'd0);
          check("bp_valid", {63'd0, ov[0]}, 64'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("bp_drain", q0.size(), 0);

    // Reset with three operations in flight.
    send(0, 32'd1, 32'd1, 1'b0, 1'b0);
    send(0, 32'd2, 32'd2, 1'b0, 1'b0);
    send(0, 32'd3, 32'd3, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #1;
      check("mid_rst_ov", {63'd0, ov[0]}, 64'd0);
      check("mid_rst_out", {29'd0, got_of(0)}, 64'd0);
    end
    @(negedge clk);
    send(0, 32'd3, 32'd4, 1'b0, 1'b0);
    wait_res(0, 4, {3'b000, 32'd7});

    // Other geometries.
    send(1, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    wait_res(1, 1, {3'b111, 32'h0});
    send(2, 32'h00008000, 32'h00008000, 1'b0, 1'b0);
    wait_res(2, 4, {3'b111, 32'h0});

    for (int d = 0; d < 3; d++) begin
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < ((d == 0) ? 300 : 1000); i++)
            send(d, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
      join
      repeat (10) @(negedge clk);
      check($sformatf("rand_drain%0d", d),
            (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined two-operand adder/subtractor; successor to the single-cycle combinational 32-bit adder.
- Splits a WIDTH-bit add into SEG-bit segments, one segment per pipeline stage, and passes the carry between stages in registers.
- Sustains one operation per cycle with valid/ready flow control.
- Flags are computed on the final result; the block sits between operand registers and the datapath ALU result mux.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG, minimum 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode are presented this cycle.
in_ready  output  1  block accepts when in_valid && in_ready.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add mode only).
sub  input  1  0 = A+B+cin; 1 = A-B (cin ignored).
out_valid  output  1  result is valid.
out_ready  input  1  downstream accepts the result.
out  output  WIDTH  sum or difference, modulo 2^WIDTH.
cout  output  1  carry out of the MSB; in sub mode 1 = no borrow.
overflow  output  1  signed (two's-complement) overflow.
zero  output  1  out == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits, out_valid, out, cout, overflow and zero clear to 0.
  - in_ready is 1 one cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight operations; no partial result is emitted.
- Operand conditioning at acceptance:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin.
- Pipeline:
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and effective B with the carry registered by stage k-1.
  - Stage 0 uses the effective carry-in.
  - Unprocessed upper segments of A and B, and already computed lower result segments, are carried forward in skew registers.
- Latency: exactly STAGES cycles from the accept edge to out_valid high when there is no stall. With WIDTH=32, SEG=8, latency is 4. With SEG=WIDTH, latency is 1.
- Throughput: one accept per cycle.
- Flow control:
  - Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every stage register holds, including out, flags and skew registers.
  - Bubbles (stage valid = 0) advance like data; they do not collapse.
- Flags are registered with the final stage and are valid only while out_valid = 1.
  - overflow = carry into MSB XOR carry out of MSB, using the effective operands.
  - zero = ~|out.
  - cout = carry out of the MSB.
- Simultaneous events:
  - An accept and a result drain in the same cycle are both legal; the pipeline advances.
  - in_valid while stalled is not accepted, and the source must hold its inputs.
- Width rules: no sign extension, no saturation; results wrap modulo 2^WIDTH.
- Elaboration: WIDTH % SEG != 0 or SEG < 1 raises an elaboration error.

Decomposition:
- Shared package add_pkg:
  - MODE_ADD = 1'b0, MODE_SUB = 1'b1.
  - Default WIDTH/SEG constants.
- Sub-module add_seg:
  - Combinational SEG-bit ripple adder with ports a, b, cin, sum, cout and c_msb (carry into the top bit, used for overflow).
  - Built from the existing full-adder cell.
  - add_pipe instantiates add_seg once per stage in a generate loop and owns all registers.

Test Plan:
1. Add, WIDTH=32, SEG=8: a=0x55555555, b=0xAAAAAAAA, cin=0, sub=0, out_ready=1 -> 4 cycles later out=0xFFFFFFFF, cout=0, overflow=0, zero=0.
2. Wrap-around: a=0xFFFFFFFF, b=0x00000001, sub=0 -> out=0x00000000, cout=1, zero=1, overflow=0.
3. Subtract: a=5, b=7, sub=1 -> out=0xFFFFFFFE, cout=0 (borrow). Then a=0x7FFFFFFF, b=1, sub=0 -> out=0x80000000, overflow=1.
4. Back-to-back and backpressure:
   - Issue 6 consecutive adds (i+i for i=1..6) with out_ready=0 from cycle 5 to cycle 8.
   - Required: in_ready=0 while out_valid && !out_ready; results 2,4,6,8,10,12 emerge in order, none lost or duplicated.
5. Reset mid-flight: accept 3 operations, assert reset for 1 cycle after the 2nd cycle -> out_valid stays 0 afterwards and all outputs read 0; a new op then completes in 4 cycles.
6. Parameter sweep: SEG=32 (latency 1) and WIDTH=16, SEG=4 (latency 4):
   - 0x8000 + 0x8000 -> out=0x0000, cout=1, overflow=1, zero=1.
   - Also run 1000 random vectors against a reference-model sum.
